// File: rtl/fifo_pkg.sv
// fifo_pkg: constants shared by the dual-clock FIFO and its read-side stream adapter
package fifo_pkg;
    localparam int DATA_SIZE  = 8;
    localparam int ADDR_SIZE  = 4;
    localparam int OBUF_DEPTH = 2;
    localparam logic [1:0] LVL_EMPTY = 2'd0;
    localparam logic [1:0] LVL_ONE   = 2'd1;
    localparam logic [1:0] LVL_FULL  = 2'd2;
endpackage

// File: rtl/obuf_2entry.sv
// obuf_2entry: two-entry circular output buffer with registered head word and fill level
module obuf_2entry
    import fifo_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         push_i,
    input  logic [W-1:0] wdata_i,
    input  logic         pop_i,
    input  logic         clr_i,
    output logic [1:0]   level_o,
    output logic [W-1:0] head_o
);
    logic [W-1:0] mem_q [OBUF_DEPTH];
    logic         head_q, tail_q;
    logic [1:0]   level_q;
    // storage, 1-bit wrapping pointers and level; clear drops every entry at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            head_q   <= 1'b0;
            tail_q   <= 1'b0;
            level_q  <= LVL_EMPTY;
        end else if (clr_i) begin
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            level_q <= LVL_EMPTY;
        end else begin
            if (push_i) mem_q[tail_q] <= wdata_i;
            tail_q  <= tail_q ^ push_i;
            head_q  <= head_q ^ pop_i;
            level_q <= level_q + 2'(push_i) - 2'(pop_i);
        end
    end
    assign level_o = level_q;
    assign head_o  = mem_q[head_q];
endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: turns the FIFO read port into a buffered valid/ready stream with a word counter
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int DATA_SIZE = fifo_pkg::DATA_SIZE,
    parameter int CNT_W     = 16
) (
    input  logic                 r_clk,
    input  logic                 r_rst_n,
    input  logic                 empty,
    input  logic [DATA_SIZE-1:0] r_data,
    output logic                 r_en,
    output logic                 out_valid,
    output logic [DATA_SIZE-1:0] out_data,
    input  logic                 out_ready,
    input  logic                 flush,
    output logic [1:0]           buf_level,
    output logic [CNT_W-1:0]     word_cnt
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hs;
    // pop only from registered level, never from out_ready; held low in reset and flush
    assign r_en      = r_rst_n && !empty && !flush && (buf_level != LVL_FULL);
    assign out_valid = buf_level != LVL_EMPTY;
    assign hs        = out_valid && out_ready;
    assign cnt_d     = hs ? cnt_q + 1'b1 : cnt_q;
    assign word_cnt  = cnt_q;
    obuf_2entry #(.W(DATA_SIZE)) u_obuf (
        .clk_i   (r_clk),
        .rst_ni  (r_rst_n),
        .push_i  (r_en),
        .wdata_i (r_data),
        .pop_i   (hs),
        .clr_i   (flush),
        .level_o (buf_level),
        .head_o  (out_data)
    );
    // delivered-word counter, wraps freely; a handshake in a flush cycle still counts
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: directed scenario tests of the read-side stream adapter against a FIFO model
module tb_fifo_rd_stream;
    logic       r_clk = 1'b0, r_rst_n = 1'b0, out_ready = 1'b0, flush = 1'b0;
    logic       empty, r_en, out_valid;
    logic [7:0] r_data, out_data;
    logic [1:0] buf_level;
    logic [3:0] word_cnt;
    logic [3:0] exp_cnt = 4'd0;
    logic [7:0] mem [0:63];
    int         wr_ptr = 0, rd_ptr = 0;
    int         errors = 0, checks = 0;

    fifo_rd_stream #(.DATA_SIZE(8), .CNT_W(4)) dut (
        .r_clk(r_clk), .r_rst_n(r_rst_n), .empty(empty), .r_data(r_data), .r_en(r_en),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .flush(flush),
        .buf_level(buf_level), .word_cnt(word_cnt)
    );

    always #5 r_clk = ~r_clk;
    assign empty  = (rd_ptr == wr_ptr);
    assign r_data = mem[rd_ptr[5:0]];
    always @(posedge r_clk or negedge r_rst_n)
        if (!r_rst_n) rd_ptr <= 0;
        else if (r_en) rd_ptr <= rd_ptr + 1;

    task automatic push(input logic [7:0] v);
        mem[wr_ptr[5:0]] = v;
        wr_ptr++;
    endtask

    task automatic test_reset;
        push(8'h77);
        #12;
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL reset_r_en: got %b expected 0", r_en); end
        checks++; if (buf_level !== 2'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", buf_level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
        checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", word_cnt); end
        wr_ptr = 0;
        @(negedge r_clk);
        r_rst_n = 1'b1;
    endtask

    task automatic test_streaming;
        @(negedge r_clk);
        out_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        #1;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL stream_r_en0: got %b expected 1", r_en); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge r_clk);
            checks++; if (out_data !== 8'(8'h11 * k) || out_valid !== 1'b1)
                begin errors++; $display("FAIL stream_data%0d: got %h/%b expected %h/1", k, out_data, out_valid, 8'(8'h11 * k)); end
            checks++; if (buf_level !== 2'd1) begin errors++; $display("FAIL stream_level%0d: got %0d expected 1", k, buf_level); end
            checks++; if (r_en !== (k < 4)) begin errors++; $display("FAIL stream_r_en%0d: got %b expected %b", k, r_en, k < 4); end
        end
        @(negedge r_clk);
        exp_cnt = exp_cnt + 4'd4;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end_valid: got %b expected 0", out_valid); end
        checks++; if (word_cnt !== exp_cnt) begin errors++; $display("FAIL stream_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_backpressure;
        @(negedge r_clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        repeat (4) @(negedge r_clk);
        checks++; if (buf_level !== 2'd2) begin errors++; $display("FAIL bp_level: got %0d expected 2", buf_level); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL bp_r_en: got %b expected 0", r_en); end
        checks++; if (out_data !== 8'hA0) begin errors++; $display("FAIL bp_hold: got %h expected a0", out_data); end
        checks++; if (rd_ptr != wr_ptr - 3) begin errors++; $display("FAIL bp_pops: got %0d left expected 3", wr_ptr - rd_ptr); end
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge r_clk);
            checks++; if (out_data !== 8'hA0 + 8'(i) || out_valid !== 1'b1)
                begin errors++; $display("FAIL bp_data%0d: got %h/%b expected %h/1", i, out_data, out_valid, 8'hA0 + 8'(i)); end
        end
        @(negedge r_clk);
        exp_cnt = exp_cnt + 4'd5;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", out_valid); end
        checks++; if (word_cnt !== exp_cnt) begin errors++; $display("FAIL bp_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
    endtask

    task automatic test_empty_boundary;
        out_ready = 1'b0;
        push(8'h5A);
        #1;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL empty_pop: got %b expected 1", r_en); end
        @(negedge r_clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin errors++; $display("FAIL empty_data: got %h/%b expected 5a/1", out_data, out_valid); end
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL empty_no_pop1: got %b expected 0", r_en); end
        @(negedge r_clk);
        checks++; if (r_en !== 1'b0 || buf_level !== 2'd1) begin errors++; $display("FAIL empty_no_pop2: got %b/%0d expected 0/1", r_en, buf_level); end
        out_ready = 1'b1;
        @(negedge r_clk);
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (out_valid !== 1'b0 || word_cnt !== exp_cnt) begin errors++; $display("FAIL empty_drain: got %b/%0d expected 0/%0d", out_valid, word_cnt, exp_cnt); end
    endtask

    task automatic test_flush;
        out_ready = 1'b0;
        push(8'h01); push(8'h02); push(8'h03);
        repeat (2) @(negedge r_clk);
        checks++; if (buf_level !== 2'd2 || out_data !== 8'h01) begin errors++; $display("FAIL flush_pre: got %0d/%h expected 2/01", buf_level, out_data); end
        out_ready = 1'b1;
        flush = 1'b1;
        #1;
        checks++; if (r_en !== 1'b0) begin errors++; $display("FAIL flush_r_en: got %b expected 0", r_en); end
        @(negedge r_clk);
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (buf_level !== 2'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_clear: got %0d/%b expected 0/0", buf_level, out_valid); end
        checks++; if (word_cnt !== exp_cnt) begin errors++; $display("FAIL flush_cnt: got %0d expected %0d", word_cnt, exp_cnt); end
        flush = 1'b0;
        #1;
        checks++; if (r_en !== 1'b1) begin errors++; $display("FAIL flush_resume: got %b expected 1", r_en); end
        @(negedge r_clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h03) begin errors++; $display("FAIL flush_next: got %h/%b expected 03/1", out_data, out_valid); end
        @(negedge r_clk);
        exp_cnt = exp_cnt + 4'd1;
        checks++; if (out_valid !== 1'b0 || word_cnt !== exp_cnt) begin errors++; $display("FAIL flush_drain: got %b/%0d expected 0/%0d", out_valid, word_cnt, exp_cnt); end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        push(8'hB0); push(8'hB1); push(8'hB2);
        repeat (2) @(negedge r_clk);
        checks++; if (buf_level !== 2'd2) begin errors++; $display("FAIL rst_mid_pre: got %0d expected 2", buf_level); end
        @(posedge r_clk);
        #2;
        r_rst_n = 1'b0;
        wr_ptr = 0;
        #1;
        exp_cnt = 4'd0;
        checks++; if (out_valid !== 1'b0 || buf_level !== 2'd0) begin errors++; $display("FAIL rst_mid_buf: got %b/%0d expected 0/0", out_valid, buf_level); end
        checks++; if (word_cnt !== 4'd0 || r_en !== 1'b0) begin errors++; $display("FAIL rst_mid_cnt: got %0d/%b expected 0/0", word_cnt, r_en); end
        @(negedge r_clk);
        r_rst_n = 1'b1;
    endtask

    task automatic test_wrap;
        @(negedge r_clk);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) push(8'(i));
        repeat (17) @(negedge r_clk);
        checks++; if (word_cnt !== 4'd0) begin errors++; $display("FAIL wrap16: got %0d expected 0", word_cnt); end
        @(negedge r_clk);
        checks++; if (word_cnt !== 4'd1 || out_valid !== 1'b0) begin errors++; $display("FAIL wrap17: got %0d/%b expected 1/0", word_cnt, out_valid); end
    endtask

    initial begin
        test_reset;
        test_streaming;
        test_backpressure;
        test_empty_boundary;
        test_flush;
        test_reset_mid;
        test_wrap;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
